// File: rtl/eth_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_buffer
// Description : Two-slot ping-pong receive frame buffer fed by AXI-Stream.
//               Good frames are stored and read by word address; bad and
//               oversize frames are discarded and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int SLOT_BYTES      = 2048,
    parameter int MAX_FRAME_BYTES = 1536,
    parameter int SLOT_ADDR_WIDTH = $clog2(SLOT_BYTES / KEEP_WIDTH)
) (
    input  logic                       logic_clk,
    input  logic                       logic_rst,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    output logic                       rx_frame_v_o,
    output logic [15:0]                rx_frame_len_o,
    input  logic [SLOT_ADDR_WIDTH-1:0] rx_rd_addr_i,
    output logic [DATA_WIDTH-1:0]      rx_rd_data_o,
    input  logic                       rx_frame_consume_i,
    output logic [15:0]                rx_drop_count_o
);

    localparam int c_SLOT_WORDS = SLOT_BYTES / KEEP_WIDTH;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RECV = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    logic [DATA_WIDTH-1:0]      r_mem [0:2*c_SLOT_WORDS-1];
    logic [1:0]                 r_state;
    logic [1:0]                 r_full;
    logic [15:0]                r_slot_len [2];
    logic                       r_wr_slot;
    logic                       r_rd_slot;
    logic [SLOT_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [15:0]                r_len;
    logic [15:0]                r_drop_count;
    logic [DATA_WIDTH-1:0]      r_rd_data;

    logic [15:0]                w_beat_bytes;
    logic [15:0]                w_new_len;
    logic                       w_oversize;
    logic                       w_ready;
    logic                       w_accept;
    logic                       w_store;
    logic [SLOT_ADDR_WIDTH-1:0] w_word;
    logic                       w_commit;
    logic                       w_drop;
    logic                       w_consume;
    logic [1:0]                 w_full_next;

    function automatic logic [15:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + 16'(k[i]);
        end
        return n;
    endfunction

    always_comb begin
        w_beat_bytes = popcount(s_axis_tkeep);
        // The first beat of a frame starts a fresh length and word 0.
        w_new_len    = ((r_state == c_IDLE) ? 16'd0 : r_len) + w_beat_bytes;
        w_word       = (r_state == c_IDLE) ? '0 : r_wr_ptr;
        w_oversize   = (w_new_len > 16'(MAX_FRAME_BYTES));
        case (r_state)
            c_IDLE:  w_ready = ~r_full[r_wr_slot];
            c_RECV:  w_ready = 1'b1;
            c_DROP:  w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
        w_accept  = s_axis_tvalid & w_ready;
        w_store   = w_accept & (r_state != c_DROP);
        w_commit  = w_store & s_axis_tlast & ~s_axis_tuser & ~w_oversize;
        w_drop    = w_accept & s_axis_tlast &
                    ((r_state == c_DROP) | s_axis_tuser | w_oversize);
        w_consume = rx_frame_consume_i & r_full[r_rd_slot];
        // Consume and commit always target different slots, so both apply.
        w_full_next = r_full;
        if (w_consume) begin
            w_full_next[r_rd_slot] = 1'b0;
        end
        if (w_commit) begin
            w_full_next[r_wr_slot] = 1'b1;
        end
    end

    always_ff @(posedge logic_clk) begin
        if (w_store) begin
            r_mem[{r_wr_slot, w_word}] <= s_axis_tdata;
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            r_state       <= c_IDLE;
            r_full        <= 2'b00;
            r_slot_len[0] <= 16'd0;
            r_slot_len[1] <= 16'd0;
            r_wr_slot     <= 1'b0;
            r_rd_slot     <= 1'b0;
            r_wr_ptr      <= '0;
            r_len         <= 16'd0;
            r_drop_count  <= 16'd0;
            r_rd_data     <= '0;
        end else begin
            r_full    <= w_full_next;
            r_rd_data <= r_mem[{r_rd_slot, rx_rd_addr_i}];
            if (w_consume) begin
                r_rd_slot <= ~r_rd_slot;
            end
            if (w_commit) begin
                r_slot_len[r_wr_slot] <= w_new_len;
                r_wr_slot             <= ~r_wr_slot;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_accept && !s_axis_tlast) begin
                        r_len    <= w_new_len;
                        r_wr_ptr <= SLOT_ADDR_WIDTH'(1);
                        r_state  <= w_oversize ? c_DROP : c_RECV;
                    end
                end
                c_RECV: begin
                    if (w_accept) begin
                        if (s_axis_tlast) begin
                            r_state <= c_IDLE;
                        end else if (w_oversize) begin
                            r_state <= c_DROP;
                        end else begin
                            r_len    <= w_new_len;
                            r_wr_ptr <= r_wr_ptr + SLOT_ADDR_WIDTH'(1);
                        end
                    end
                end
                c_DROP: begin
                    if (w_accept && s_axis_tlast) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign s_axis_tready   = w_ready & ~logic_rst;
    assign rx_frame_v_o    = r_full[r_rd_slot];
    assign rx_frame_len_o  = r_full[r_rd_slot] ? r_slot_len[r_rd_slot] : 16'd0;
    assign rx_rd_data_o    = r_rd_data;
    assign rx_drop_count_o = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_frame_buffer
// Description : Directed self-checking bench for eth_rx_frame_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_frame_buffer;

    logic        logic_clk = 1'b0;
    logic        logic_rst;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        rx_frame_v_o;
    logic [15:0] rx_frame_len_o;
    logic [8:0]  rx_rd_addr_i;
    logic [31:0] rx_rd_data_o;
    logic        rx_frame_consume_i;
    logic [15:0] rx_drop_count_o;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    eth_rx_frame_buffer dut (
        .logic_clk          (logic_clk),
        .logic_rst          (logic_rst),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tuser       (s_axis_tuser),
        .rx_frame_v_o       (rx_frame_v_o),
        .rx_frame_len_o     (rx_frame_len_o),
        .rx_rd_addr_i       (rx_rd_addr_i),
        .rx_rd_data_o       (rx_rd_data_o),
        .rx_frame_consume_i (rx_frame_consume_i),
        .rx_drop_count_o    (rx_drop_count_o)
    );

    always #5 logic_clk = ~logic_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_word(input int seed, input int i);
        logic [31:0] s;
        logic [31:0] w;
        s = 32'(seed);
        w = 32'(i);
        return {s[7:0], 8'hC3, w[15:0]};
    endfunction

    function automatic logic [3:0] keep_for(input int rem);
        if (rem >= 4) return 4'hF;
        else if (rem == 3) return 4'h7;
        else if (rem == 2) return 4'h3;
        else return 4'h1;
    endfunction

    // Drives one frame; inputs change 1 time unit after a rising edge.
    task automatic send_frame(input int nbytes, input logic bad, input int seed, output int nstall);
        int nbeats;
        int waited;
        nbeats = (nbytes + 3) / 4;
        nstall = 0;
        for (int i = 0; i < nbeats; i++) begin
            s_axis_tdata  = beat_word(seed, i);
            s_axis_tkeep  = keep_for(nbytes - 4 * i);
            s_axis_tlast  = (i == nbeats - 1);
            s_axis_tuser  = bad && (i == nbeats - 1);
            s_axis_tvalid = 1'b1;
            waited = 0;
            while (!s_axis_tready && waited < 1000) begin
                @(posedge logic_clk); #1;
                waited++;
                nstall++;
            end
            if (waited >= 1000) begin
                check("tready_timeout", 32'(s_axis_tready), 32'd1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(posedge logic_clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic read_word(input int addr, output logic [31:0] data);
        rx_rd_addr_i = 9'(addr);
        @(posedge logic_clk); #1;
        data = rx_rd_data_o;
    endtask

    task automatic check_frame(input string tag, input int seed, input int nbytes);
        logic [31:0] d;
        logic [31:0] mask;
        int nbeats;
        nbeats = (nbytes + 3) / 4;
        for (int i = 0; i < nbeats; i++) begin
            read_word(i, d);
            mask = {{8{keep_for(nbytes - 4 * i)}}} == 32'hFFFFFFFF ? 32'hFFFFFFFF : 32'h0;
            case (keep_for(nbytes - 4 * i))
                4'h1:    mask = 32'h0000_00FF;
                4'h3:    mask = 32'h0000_FFFF;
                4'h7:    mask = 32'h00FF_FFFF;
                default: mask = 32'hFFFF_FFFF;
            endcase
            check(tag, d & mask, beat_word(seed, i) & mask);
        end
    endtask

    task automatic consume();
        rx_frame_consume_i = 1'b1;
        @(posedge logic_clk); #1;
        rx_frame_consume_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic_rst          = 1'b1;
        s_axis_tdata       = '0;
        s_axis_tkeep       = '0;
        s_axis_tvalid      = 1'b0;
        s_axis_tlast       = 1'b0;
        s_axis_tuser       = 1'b0;
        rx_rd_addr_i       = '0;
        rx_frame_consume_i = 1'b0;

        // Reset values
        repeat (2) @(posedge logic_clk);
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_v", 32'(rx_frame_v_o), 32'd0);
        check("rst_len", 32'(rx_frame_len_o), 32'd0);
        check("rst_rdata", rx_rd_data_o, 32'd0);
        check("rst_drops", 32'(rx_drop_count_o), 32'd0);
        logic_rst = 1'b0;
        #1;
        check("post_rst_tready", 32'(s_axis_tready), 32'd1);

        // Consume with nothing valid must be ignored
        consume();
        check("idle_consume_v", 32'(rx_frame_v_o), 32'd0);

        // 64-byte good frame -> slot 0
        send_frame(64, 1'b0, 1, stalls);
        check("f64_v", 32'(rx_frame_v_o), 32'd1);
        check("f64_len", 32'(rx_frame_len_o), 32'd64);
        check_frame("f64_data", 1, 64);
        consume();
        check("f64_consumed_v", 32'(rx_frame_v_o), 32'd0);
        check("f64_consumed_len", 32'(rx_frame_len_o), 32'd0);

        // 61-byte frame -> slot 1
        send_frame(61, 1'b0, 2, stalls);
        check("f61_v", 32'(rx_frame_v_o), 32'd1);
        check("f61_len", 32'(rx_frame_len_o), 32'd61);
        read_word(15, d);
        check("f61_w15_b0", {24'd0, d[7:0]}, {24'd0, beat_word(2, 15) & 32'hFF});
        check_frame("f61_data", 2, 61);
        consume();

        // Bad frame dropped, then 60-byte good frame in slot 0
        send_frame(100, 1'b1, 3, stalls);
        check("bad_v", 32'(rx_frame_v_o), 32'd0);
        check("bad_drops", 32'(rx_drop_count_o), 32'd1);
        send_frame(60, 1'b0, 4, stalls);
        check("f60_v", 32'(rx_frame_v_o), 32'd1);
        check("f60_len", 32'(rx_frame_len_o), 32'd60);
        check_frame("f60_data", 4, 60);
        consume();

        // Oversize frame dropped without backpressure, then 100-byte frame
        send_frame(1600, 1'b0, 5, stalls);
        check("ovs_stalls", 32'(stalls), 32'd0);
        check("ovs_v", 32'(rx_frame_v_o), 32'd0);
        check("ovs_drops", 32'(rx_drop_count_o), 32'd2);
        send_frame(100, 1'b0, 6, stalls);
        check("f100_v", 32'(rx_frame_v_o), 32'd1);
        check("f100_len", 32'(rx_frame_len_o), 32'd100);
        check_frame("f100_data", 6, 100);
        consume();

        // Three back-to-back frames without consume
        send_frame(64, 1'b0, 10, stalls);
        send_frame(64, 1'b0, 11, stalls);
        check("b2b_stalls", 32'(stalls), 32'd0);
        check("b2b_v", 32'(rx_frame_v_o), 32'd1);
        fork
            begin
                send_frame(64, 1'b0, 12, stalls);
            end
            begin
                check("b2b_full_tready", 32'(s_axis_tready), 32'd0);
                repeat (3) @(posedge logic_clk);
                #1;
                check("b2b_still_blocked", 32'(s_axis_tready), 32'd0);
                check("b2b_f1_len", 32'(rx_frame_len_o), 32'd64);
                check_frame("b2b_f1_data", 10, 64);
                consume();
                check("b2b_tready_freed", 32'(s_axis_tready), 32'd1);
            end
        join
        check("b2b_f2_len", 32'(rx_frame_len_o), 32'd64);
        check_frame("b2b_f2_data", 11, 64);
        consume();
        check("b2b_f3_v", 32'(rx_frame_v_o), 32'd1);
        check("b2b_f3_len", 32'(rx_frame_len_o), 32'd64);
        check_frame("b2b_f3_data", 12, 64);
        consume();
        check("b2b_empty_v", 32'(rx_frame_v_o), 32'd0);

        // Commit into one slot while the other is consumed in the same cycle
        send_frame(64, 1'b0, 20, stalls);
        check("cc_first_v", 32'(rx_frame_v_o), 32'd1);
        fork
            begin
                send_frame(40, 1'b0, 21, stalls);
            end
            begin
                repeat (9) @(posedge logic_clk);
                #1;
                rx_frame_consume_i = 1'b1;
                @(posedge logic_clk); #1;
                rx_frame_consume_i = 1'b0;
            end
        join
        check("cc_v", 32'(rx_frame_v_o), 32'd1);
        check("cc_len", 32'(rx_frame_len_o), 32'd40);
        check("cc_tready", 32'(s_axis_tready), 32'd1);
        check_frame("cc_data", 21, 40);

        // Drop counter saturation with single-beat bad frames
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (65533) @(posedge logic_clk);
        #1;
        s_axis_tvalid = 1'b0;
        check("sat_reach", 32'(rx_drop_count_o), 32'hFFFF);
        send_frame(8, 1'b1, 30, stalls);
        check("sat_hold", 32'(rx_drop_count_o), 32'hFFFF);
        check("sat_v", 32'(rx_frame_v_o), 32'd1);
        check("sat_len", 32'(rx_frame_len_o), 32'd40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_rx_frame_buffer.md
# eth_rx_frame_buffer

Receive-side frame buffer in the `logic_clk` domain. It consumes the AXI-Stream output of the 1G RGMII MAC's RX FIFO and stores complete, good frames in a two-slot ping-pong buffer. Software reads each stored frame by word address and then releases the slot. Bad frames (`tuser`=1) and oversize frames are discarded and counted.

## Interface

Parameters:

- `DATA_WIDTH`, 32, stream and read-port word width; must equal the RX FIFO `AXIS_DATA_WIDTH`.
- `KEEP_WIDTH`, `DATA_WIDTH/8`, bytes per word.
- `SLOT_BYTES`, 2048, capacity of one slot in bytes; power of two.
- `MAX_FRAME_BYTES`, 1536, largest accepted frame; must be ≤ `SLOT_BYTES`.
- `SLOT_ADDR_WIDTH`, `$clog2(SLOT_BYTES/KEEP_WIDTH)`, word-address width.

Ports:

- `logic_clk` in 1: sole clock.
- `logic_rst` in 1: reset, synchronous, active-high.
- `s_axis_tdata` in `DATA_WIDTH`: receive data; byte 0 in bits [7:0].
- `s_axis_tkeep` in `KEEP_WIDTH`: byte enables; contiguous from bit 0; all ones except on the `tlast` beat.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tready` out 1: beat accept.
- `s_axis_tlast` in 1: final beat of the frame.
- `s_axis_tuser` in 1: bad-frame flag; sampled on the `tlast` beat only.
- `rx_frame_v_o` out 1: the current read slot holds a complete frame.
- `rx_frame_len_o` out 16: byte length of the current read-slot frame; 0 when `rx_frame_v_o`=0.
- `rx_rd_addr_i` in `SLOT_ADDR_WIDTH`: word address within the current read slot.
- `rx_rd_data_o` out `DATA_WIDTH`: read data for the address.
- `rx_frame_consume_i` in 1: single-cycle pulse that releases the current read slot.
- `rx_drop_count_o` out 16: count of dropped frames; saturates at 16'hFFFF.

## Operation

Storage:

- Two slots, each `SLOT_BYTES/KEEP_WIDTH` words, held as one memory indexed by {slot, word}.
- Per-slot state: `full` bit and 16-bit length.
- Pointers: `wr_slot` and `rd_slot`, both 1 bit, reset to 0.

Write FSM (states IDLE, RECV, DROP):

- **IDLE**:
  - `s_axis_tready` = !`full[wr_slot]`.
  - An accepted beat is written to word 0 and `len` = popcount(`tkeep`). Go to RECV, or go directly to the commit/drop decision if `tlast`=1.
  - When the write slot is full, the block backpressures. It never drops on full; the upstream FIFO absorbs or drops.
- **RECV**:
  - `s_axis_tready`=1. Each accepted beat is written at `wr_ptr`, `wr_ptr` increments, and `len` += popcount(`tkeep`).
  - If `len` + popcount(`tkeep`) > `MAX_FRAME_BYTES` on a non-last beat, go to DROP.
  - On a `tlast` beat, apply the oversize check to that beat as well.
- **DROP**:
  - `s_axis_tready`=1. Beats are discarded.
  - On `tlast`, increment `rx_drop_count_o` (saturating) and go to IDLE.
- **End of frame** (`tlast` beat accepted in IDLE or RECV):
  - Good (`tuser`=0 and not oversize): set `full[wr_slot]`, store `len`, toggle `wr_slot`, go to IDLE.
  - Bad (`tuser`=1 or oversize): increment the drop count. The slot stays empty and is reused by the next frame. Go to IDLE.
- Partial frames never become visible to the read side.

Read side:

- `rx_frame_v_o` = `full[rd_slot]`.
- `rx_frame_len_o` = `len[rd_slot]` when valid, else 0.
- `rx_frame_consume_i` while `rx_frame_v_o`=1 clears `full[rd_slot]` and toggles `rd_slot`. A consume pulse while `rx_frame_v_o`=0 is ignored.
- Frames are delivered in arrival order.

Simultaneous events:

- A commit into one slot and a consume of the other slot in the same cycle both take effect.
- A commit never targets `rd_slot` while that slot is full.

Width rules:

- `wr_ptr` is `SLOT_ADDR_WIDTH` bits wide and never wraps, because `MAX_FRAME_BYTES` ≤ `SLOT_BYTES`.
- `len` is 16 bits.

## Timing

- Reset (one cycle of `logic_rst`=1):
  - FSM goes to IDLE; slots empty; both pointers 0; drop count 0.
  - `rx_frame_v_o`=0, `rx_frame_len_o`=0, `rx_rd_data_o`=0, `s_axis_tready`=0 during reset.
  - `s_axis_tready`=1 on the first cycle after reset.
  - Reset mid-frame discards the partial frame. The upstream RX FIFO shares `logic_rst`, so no stale beats follow the reset.
- `s_axis_tready` is combinational from state and `full` only; it never depends on `s_axis_tvalid`.
- Commit latency: on a `tlast` beat accepted at cycle N, `rx_frame_v_o` and `rx_frame_len_o` are valid at N+1. The drop count updates at N+1.
- Read latency: `rx_rd_data_o` is registered and reflects `rx_rd_addr_i` and `rd_slot` from the previous cycle, a 1-cycle latency.
- Consume at cycle N: at N+1, `rx_frame_v_o`/`rx_frame_len_o` reflect the other slot.
- A freed write slot raises `s_axis_tready` at N+1.
- Throughput is one beat per cycle, with no idle cycles required between frames.

## Test plan

- **64-byte good frame**: 16 beats, `tkeep`=4'hF, last `tuser`=0 → `rx_frame_v_o`=1 the cycle after `tlast`; `len`=64; reads of addresses 0–15 return the sent words.
- **61-byte frame, last `tkeep`=4'b0001** → `len`=61; word 15 bits [7:0] match the sent byte.
- **Bad frame** (100 bytes, `tuser`=1 on `tlast`) → `rx_frame_v_o` stays 0; `rx_drop_count_o`=1; a following 60-byte good frame appears in slot 0 with `len`=60.
- **Oversize frame** (1600 bytes) → `tready` stays 1 through `tlast`; frame not stored; drop count increments; a following 100-byte frame is accepted with `len`=100.
- **Three back-to-back 64-byte frames, no consume** → frames 1 and 2 are stored; `tready`=0 at the start of frame 3; a consume raises `tready` the next cycle; frame 3 is stored; lengths and data arrive in order.
- **Consume and commit in the same cycle**, plus drop-count saturation: preset 65535 drops, then one more bad frame → both slot updates take effect; the counter stays at 16'hFFFF.
